// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory stage.
// State encoding, opcode constants and default bus widths.
package mips_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CTR_W      = 8;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } mem_state_e;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_unit_if.sv
// Request/acknowledge bus between the memory stage and external memory.
// master = memory stage, slave = memory model or bus bridge.
interface mem_unit_if
    import mips_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for outstanding memory accesses.
// tc is high while the count equals TIMEOUT-1.
module mem_timeout_ctr
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CTR_W-1:0] TC_VAL = CTR_W'(TIMEOUT - 1);

    logic [CTR_W-1:0] cnt_q;
    logic [CTR_W-1:0] cnt_d;

    // Clear has priority over counting
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + {{(CTR_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_unit.sv
// Unified-memory access stage: one req/ack transaction per controller state.
// Latches IR/MDR, stalls the controller, flags timeout and misalignment.
module mem_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wd,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic              stall,
    output logic [DATA_W-1:0] Instr,
    output logic [5:0]        Opcode,
    output logic [5:0]        Funct,
    output logic [DATA_W-1:0] Data,
    output logic              err,
    mem_unit_if.master        mem
);

    mem_state_e        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              ld_ir_q, ld_ir_d;
    logic              ld_dr_q, ld_dr_d;

    logic              acc;
    logic [ADDR_W-1:0] addr;
    logic              ctr_clr;
    logic              ctr_en;
    logic              ctr_tc;

    assign acc  = IRWrite | MemRead | MemWrite;
    assign addr = IorD ? alu_out : pc;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .tc    (ctr_tc)
    );

    // Next state and datapath updates; register loads are chosen at issue
    // so strobes dropping mid-access cannot change the outcome
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        instr_d     = instr_q;
        data_d      = data_q;
        err_d       = err_q;
        ld_ir_d     = ld_ir_q;
        ld_dr_d     = ld_dr_q;
        ctr_clr     = 1'b0;
        ctr_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    if (!word_aligned(addr[1:0])) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ST_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = addr;
                        mem_wdata_d = wd;
                        ld_ir_d     = IRWrite & ~MemWrite;
                        ld_dr_d     = MemRead & ~MemWrite;
                        ctr_clr     = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (mem.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    if (ld_ir_q) begin
                        instr_d = mem.mem_rdata;
                    end
                    if (ld_dr_q) begin
                        data_d = mem.mem_rdata;
                    end
                end else if (ctr_tc) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_ERR;
                end else begin
                    ctr_en = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                mem_req_d = 1'b0;
                err_d     = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            instr_q     <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            ld_ir_q     <= 1'b0;
            ld_dr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            instr_q     <= instr_d;
            data_q      <= data_d;
            err_q       <= err_d;
            ld_ir_q     <= ld_ir_d;
            ld_dr_q     <= ld_dr_d;
        end
    end

    assign stall = (acc && (state_q != ST_DONE)) || (state_q == ST_ERR);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign Instr  = instr_q;
    assign Opcode = instr_q[31:26];
    assign Funct  = instr_q[5:0];
    assign Data   = data_q;
    assign err    = err_q;

endmodule
